// File: rtl/lfsr_word_gen.sv
// Fibonacci LFSR word generator: packs OUT_BITS feedback bits per word and delivers them
// over valid/ready with backpressure, runtime reseeding and all-zero lockup recovery.
module lfsr_word_gen #(
   parameter int unsigned      WIDTH    = 168,
   parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'({1'b1, 1'b0, 1'b1, 12'b0, 1'b1, 1'b0, 1'b1, 150'b0}),
   parameter logic [WIDTH-1:0] INIT     = WIDTH'(1),
   parameter int unsigned      SEED_W   = 28,
   parameter int unsigned      OUT_BITS = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                seed_load,
   input  logic [SEED_W-1:0]   seed,
   output logic [OUT_BITS-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                bit_o,
   output logic                lockup
);

   localparam int unsigned      REPS     = (WIDTH + SEED_W - 1) / SEED_W;
   localparam int unsigned      COLL_W   = (OUT_BITS > 1) ? OUT_BITS - 1 : 1;
   localparam int unsigned      CNT_W    = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_BITS - 1);

   logic [WIDTH-1:0]       state;
   logic [COLL_W-1:0]      collector;
   logic [CNT_W-1:0]       bit_cnt;
   logic [REPS*SEED_W-1:0] seed_rep;
   logic [WIDTH-1:0]       seed_state;
   logic [OUT_BITS-1:0]    word;
   logic                   fb;
   logic                   state_zero;
   logic                   last_bit;
   logic                   slot_free;
   logic                   advance;

   assign seed_rep   = {REPS{seed}};
   assign seed_state = INIT ^ seed_rep[WIDTH-1:0];
   assign fb         = ^(state & TAP_MASK);
   assign bit_o      = fb;
   assign state_zero = (state == '0);
   assign last_bit   = (bit_cnt == LAST_CNT);

   // Handshake: a word transfers on a cycle with out_valid && out_ready; while out_valid is
   // high and out_ready low, out_data is held. The slot is free if empty or draining now.
   assign slot_free  = !out_valid || out_ready;
   // Only the word-completing bit waits for the slot; partial bits keep shifting.
   assign advance    = en && (!last_bit || slot_free);
   // For OUT_BITS == 1 the cast keeps only fb, so the collector plays no part.
   assign word       = OUT_BITS'({collector, fb});

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INIT;
         collector <= '0;
         bit_cnt   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         lockup    <= 1'b0;
      end else begin
         lockup <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (seed_load) begin
            // A reseed drops any partial word but leaves a held output word alone.
            collector <= '0;
            bit_cnt   <= '0;
            if (seed_state == '0) begin
               state  <= INIT;
               lockup <= 1'b1;
            end else begin
               state <= seed_state;
            end
         end else if (state_zero) begin
            state  <= INIT;
            lockup <= 1'b1;
         end else if (advance) begin
            state <= {state[WIDTH-2:0], fb};
            if (last_bit) begin
               out_data  <= word;
               out_valid <= 1'b1;
               bit_cnt   <= '0;
            end else begin
               collector <= COLL_W'({collector, fb});
               bit_cnt   <= bit_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Directed bench for lfsr_word_gen: a 4-bit instance for word/handshake/seed scenarios
// and a default 168-bit instance for lockup recovery, seed expansion and reset.
module tb_lfsr_word_gen;

   localparam int BW = 168;
   localparam logic [BW-1:0] BIG_INIT = BW'(1);

   typedef struct {
      logic       en;
      logic       ready;
      logic       exp_valid;
      logic [3:0] exp_data;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, seed_load, out_ready;
   logic [3:0] seed;
   logic [3:0] out_data;
   logic       out_valid, bit_o, lockup;

   logic        b_en, b_seed_load, b_ready;
   logic [27:0] b_seed;
   logic [7:0]  b_data;
   logic        b_valid, b_bit, b_lockup;

   int   total = 0;
   int   bad   = 0;
   vec_t vec1[$];
   vec_t vec5[$];
   logic [3:0] words [4];

   always #5 clk = ~clk;

   lfsr_word_gen #(
      .WIDTH(4), .TAP_MASK(4'b1100), .INIT(4'h1), .SEED_W(4), .OUT_BITS(4)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed(seed),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .bit_o(bit_o), .lockup(lockup)
   );

   lfsr_word_gen dut_big (
      .clk(clk), .reset(reset), .en(b_en), .seed_load(b_seed_load), .seed(b_seed),
      .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
      .bit_o(b_bit), .lockup(b_lockup)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      en          = 1'b0;
      seed_load   = 1'b0;
      seed        = 4'h0;
      out_ready   = 1'b1;
      b_en        = 1'b0;
      b_seed_load = 1'b0;
      b_seed      = 28'h0;
      b_ready     = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      vec_t v;
      int   ecount;
      logic [3:0] last;

      // Words of x^4+x^3+1 from state 4'h1, first bit at the MSB.
      words[0] = 4'h3;
      words[1] = 4'h5;
      words[2] = 4'hE;
      words[3] = 4'h2;

      // Free-running stream: one word every 4 cycles, dropped the cycle after.
      for (int i = 1; i <= 16; i++) begin
         v.en        = 1'b1;
         v.ready     = 1'b1;
         v.exp_valid = (i % 4 == 0);
         v.exp_data  = (i < 4) ? 4'h0 : words[i/4 - 1];
         vec1.push_back(v);
      end

      // en pattern 1,0,0,1 repeating: words land on every 4th enabled cycle.
      ecount = 0;
      last   = 4'h0;
      for (int c = 0; c < 32; c++) begin
         v.en    = (c % 4 == 0) || (c % 4 == 3);
         v.ready = 1'b1;
         if (v.en) ecount++;
         v.exp_valid = v.en && (ecount % 4 == 0);
         if (v.exp_valid) last = words[ecount/4 - 1];
         v.exp_data = last;
         vec5.push_back(v);
      end

      // Scenario 1: reset state and free-running words
      do_reset();
      check("rst_valid", BW'(out_valid), BW'(0));
      check("rst_data", BW'(out_data), BW'(0));
      check("rst_lockup", BW'(lockup), BW'(0));
      check("rst_state", BW'(dut.state), BW'(1));
      for (int i = 0; i < vec1.size(); i++) begin
         en        = vec1[i].en;
         out_ready = vec1[i].ready;
         tick();
         check($sformatf("s1_valid[%0d]", i), BW'(out_valid), BW'(vec1[i].exp_valid));
         check($sformatf("s1_data[%0d]", i), BW'(out_data), BW'(vec1[i].exp_data));
         if (i == 14) check("s1_period", BW'(dut.state), BW'(1));
      end

      // Scenario 2: backpressure after the first word
      do_reset();
      en        = 1'b1;
      out_ready = 1'b1;
      repeat (4) tick();
      check("s2_first_valid", BW'(out_valid), BW'(1));
      check("s2_first_data", BW'(out_data), BW'(4'h3));
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("s2_hold_valid[%0d]", i), BW'(out_valid), BW'(1));
         check($sformatf("s2_hold_data[%0d]", i), BW'(out_data), BW'(4'h3));
      end
      check("s2_stall_cnt", BW'(dut.bit_cnt), BW'(3));
      check("s2_stall_state", BW'(dut.state), BW'(4'hA));
      check("s2_stall_bit", BW'(bit_o), BW'(1));
      out_ready = 1'b1;
      tick();
      check("s2_w2_valid", BW'(out_valid), BW'(1));
      check("s2_w2_data", BW'(out_data), BW'(4'h5));
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("s2_gap_valid[%0d]", i), BW'(out_valid), BW'(0));
      end
      tick();
      check("s2_w3_valid", BW'(out_valid), BW'(1));
      check("s2_w3_data", BW'(out_data), BW'(4'hE));

      // Scenario 3: seed expanding to zero, then a normal seed
      do_reset();
      en        = 1'b1;
      seed_load = 1'b1;
      seed      = 4'h1;
      tick();
      check("s3_zero_lockup", BW'(lockup), BW'(1));
      check("s3_zero_state", BW'(dut.state), BW'(1));
      seed_load = 1'b0;
      en        = 1'b0;
      tick();
      check("s3_lockup_drop", BW'(lockup), BW'(0));
      check("s3_state_frozen", BW'(dut.state), BW'(1));
      seed_load = 1'b1;
      seed      = 4'h8;
      tick();
      seed_load = 1'b0;
      check("s3_seed_state", BW'(dut.state), BW'(4'h9));
      check("s3_seed_lockup", BW'(lockup), BW'(0));
      // 4'b1001: taps 3 and 2 give 1^0.
      check("s3_seed_fb", BW'(bit_o), BW'(1));

      // Scenario 4: reseed mid-word while a word is held
      do_reset();
      en        = 1'b1;
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      repeat (2) tick();
      check("s4_cnt_before", BW'(dut.bit_cnt), BW'(2));
      seed_load = 1'b1;
      seed      = 4'h8;
      tick();
      seed_load = 1'b0;
      check("s4_held_valid", BW'(out_valid), BW'(1));
      check("s4_held_data", BW'(out_data), BW'(4'h3));
      check("s4_cnt_cleared", BW'(dut.bit_cnt), BW'(0));
      check("s4_state", BW'(dut.state), BW'(4'h9));
      out_ready = 1'b1;
      tick();
      check("s4_drain_valid", BW'(out_valid), BW'(0));
      repeat (2) tick();
      check("s4_gap_valid", BW'(out_valid), BW'(0));
      tick();
      check("s4_fresh_valid", BW'(out_valid), BW'(1));
      check("s4_fresh_data", BW'(out_data), BW'(4'hA));

      // Scenario 5: en gaps stretch timing only
      do_reset();
      for (int i = 0; i < vec5.size(); i++) begin
         en        = vec5[i].en;
         out_ready = vec5[i].ready;
         tick();
         check($sformatf("s5_valid[%0d]", i), BW'(out_valid), BW'(vec5[i].exp_valid));
         check($sformatf("s5_data[%0d]", i), BW'(out_data), BW'(vec5[i].exp_data));
      end

      // Scenario 6: default config, lockup recovery, seed expansion, reset mid-handshake
      do_reset();
      check("s6_rst_state", dut_big.state, BIG_INIT);
      check("s6_rst_valid", BW'(b_valid), BW'(0));
      b_en = 1'b1;
      repeat (2) tick();
      check("s6_cnt_pre", BW'(dut_big.bit_cnt), BW'(2));
      force dut_big.state = '0;
      #1 release dut_big.state;
      check("s6_zero_fb", BW'(b_bit), BW'(0));
      tick();
      check("s6_lockup", BW'(b_lockup), BW'(1));
      check("s6_recover_state", dut_big.state, BIG_INIT);
      check("s6_no_bit", BW'(dut_big.bit_cnt), BW'(2));
      tick();
      check("s6_lockup_drop", BW'(b_lockup), BW'(0));
      check("s6_cnt_post", BW'(dut_big.bit_cnt), BW'(3));

      b_seed_load = 1'b1;
      b_seed      = 28'h8000000;
      tick();
      b_seed_load = 1'b0;
      check("s6_seed_state", dut_big.state, {6{28'h8000000}} ^ BIG_INIT);
      check("s6_seed_cnt", BW'(dut_big.bit_cnt), BW'(0));
      check("s6_seed_fb", BW'(b_bit), BW'(1));
      repeat (7) tick();
      check("s6_pre_word", BW'(b_valid), BW'(0));
      tick();
      check("s6_word_valid", BW'(b_valid), BW'(1));
      check("s6_word_data", BW'(b_data), BW'(8'h80));
      b_ready = 1'b0;
      reset   = 1'b1;
      tick();
      reset = 1'b0;
      check("s6_rst_mid_valid", BW'(b_valid), BW'(0));
      check("s6_rst_mid_data", BW'(b_data), BW'(0));
      check("s6_rst_mid_state", dut_big.state, BIG_INIT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
